// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline control unit: memory-handshake FSM states,
// hazard classes and forwarding-select encodings.
package pipe_pkg;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_t;

    // Listed in decreasing priority.
    typedef enum logic [2:0] {
        H_FREEZE    = 3'd0,
        H_REDIRECT  = 3'd1,
        H_LOADUSE   = 3'd2,
        H_FETCHWAIT = 3'd3,
        H_NORMAL    = 3'd4
    } hazard_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/Reg.sv
// Generic register with synchronous active-high reset to zero and write enable.
module Reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wen,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (wen) q_d = d;
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Forward-select for one E-stage source operand; the younger producer in M
// wins over the older one in W, and x0 is never forwarded.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic       v_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_m,
    input  logic       v_w,
    input  logic       reg_write_w,
    input  logic [4:0] rd_w,
    input  logic [4:0] rs,
    output logic [1:0] sel
);

    logic hit_m;
    logic hit_w;

    always_comb begin
        hit_m = v_m & reg_write_m & (rd_m != 5'd0) & (rd_m == rs);
        hit_w = v_w & reg_write_w & (rd_w != 5'd0) & (rd_w == rs);
        sel   = FWD_RF;
        if (hit_m)      sel = FWD_M;
        else if (hit_w) sel = FWD_W;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline control: buffer write enables, slot-valid tracking,
// data-memory handshake, E-stage forwarding selects and retire counting.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_ready,
    input  logic             use_rs1_D,
    input  logic             use_rs2_D,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rd_E,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic             MemRead_E,
    input  logic             RegWrite_E,
    input  logic             redirect_E,
    input  logic [4:0]       Rd_M,
    input  logic             MemRead_M,
    input  logic             MemWrite_M,
    input  logic             RegWrite_M,
    input  logic [4:0]       Rd_W,
    input  logic             RegWrite_W,
    input  logic             dmem_ack,
    output logic             pc_wen,
    output logic             wen_FD,
    output logic             wen_DE,
    output logic             wen_EM,
    output logic             wen_MW,
    output logic             vD,
    output logic             vE,
    output logic             vM,
    output logic             vW,
    output logic             dmem_req,
    output logic [1:0]       fwdA_E,
    output logic [1:0]       fwdB_E,
    output logic [CNT_W-1:0] instret
);

    mem_state_t       state_q;
    mem_state_t       state_d;
    hazard_t          hz;
    logic             freeze;
    logic             redirect;
    logic             loaduse;
    logic             v_wen;
    logic             vD_d;
    logic             vE_d;
    logic             vM_d;
    logic             vW_d;
    logic             instret_wen;
    logic [CNT_W-1:0] instret_d;

    // Hazard detection does not depend on whether E writes a register.
    logic unused_regwrite_e;
    assign unused_regwrite_e = RegWrite_E;

    always_comb begin
        dmem_req = (state_q == M_WAIT) | (vM & (MemRead_M | MemWrite_M));
        freeze   = dmem_req & ~dmem_ack;
        redirect = redirect_E & vE;
        loaduse  = vD & vE & MemRead_E & (Rd_E != 5'd0) &
                   ((use_rs1_D & (Rs1_D == Rd_E)) | (use_rs2_D & (Rs2_D == Rd_E)));

        if (freeze)           hz = H_FREEZE;
        else if (redirect)    hz = H_REDIRECT;
        else if (loaduse)     hz = H_LOADUSE;
        else if (!imem_ready) hz = H_FETCHWAIT;
        else                  hz = H_NORMAL;
    end

    // Bubbles live only in the valid bits; buffers may capture stale data.
    always_comb begin
        pc_wen = 1'b1;
        wen_FD = 1'b1;
        wen_DE = 1'b1;
        wen_EM = 1'b1;
        wen_MW = 1'b1;
        vD_d   = 1'b1;
        vE_d   = vD;
        vM_d   = vE;
        vW_d   = vM;
        case (hz)
            H_FREEZE: begin
                pc_wen = 1'b0;
                wen_FD = 1'b0;
                wen_DE = 1'b0;
                wen_EM = 1'b0;
                wen_MW = 1'b0;
                vD_d   = vD;
                vE_d   = vE;
                vM_d   = vM;
                vW_d   = vW;
            end
            H_REDIRECT: begin
                vD_d = 1'b0;
                vE_d = 1'b0;
            end
            H_LOADUSE: begin
                pc_wen = 1'b0;
                wen_FD = 1'b0;
                vD_d   = vD;
                vE_d   = 1'b0;
            end
            H_FETCHWAIT: begin
                pc_wen = 1'b0;
                vD_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            M_IDLE:  if (freeze)   state_d = M_WAIT;
            M_WAIT:  if (dmem_ack) state_d = M_IDLE;
            default: state_d = M_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= M_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        v_wen       = ~freeze;
        instret_wen = wen_MW & vM;
        instret_d   = instret + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    Reg #(.W(1)) u_vD (.clk(clk), .rst(rst), .wen(v_wen), .d(vD_d), .q(vD));
    Reg #(.W(1)) u_vE (.clk(clk), .rst(rst), .wen(v_wen), .d(vE_d), .q(vE));
    Reg #(.W(1)) u_vM (.clk(clk), .rst(rst), .wen(v_wen), .d(vM_d), .q(vM));
    Reg #(.W(1)) u_vW (.clk(clk), .rst(rst), .wen(v_wen), .d(vW_d), .q(vW));

    Reg #(.W(CNT_W)) u_instret (
        .clk(clk), .rst(rst), .wen(instret_wen), .d(instret_d), .q(instret)
    );

    fwd_unit u_fwd_a (
        .v_m(vM), .reg_write_m(RegWrite_M), .rd_m(Rd_M),
        .v_w(vW), .reg_write_w(RegWrite_W), .rd_w(Rd_W),
        .rs(Rs1_E), .sel(fwdA_E)
    );

    fwd_unit u_fwd_b (
        .v_m(vM), .reg_write_m(RegWrite_M), .rd_m(Rd_M),
        .v_w(vW), .reg_write_w(RegWrite_W), .rd_w(Rd_W),
        .rs(Rs2_E), .sel(fwdB_E)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus randomized cycles
// against a slot-shifting reference model.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ready;
    logic        use_rs1_D, use_rs2_D;
    logic [4:0]  Rs1_D, Rs2_D;
    logic [4:0]  Rd_E, Rs1_E, Rs2_E;
    logic        MemRead_E, RegWrite_E, redirect_E;
    logic [4:0]  Rd_M;
    logic        MemRead_M, MemWrite_M, RegWrite_M;
    logic [4:0]  Rd_W;
    logic        RegWrite_W;
    logic        dmem_ack;
    logic        pc_wen, wen_FD, wen_DE, wen_EM, wen_MW;
    logic        vD, vE, vM, vW;
    logic        dmem_req;
    logic [1:0]  fwdA_E, fwdB_E;
    logic [31:0] instret;

    int total  = 0;
    int passed = 0;

    // Reference model state: slot valids packed {D,E,M,W}, wait flag, retire count.
    logic [3:0]  mvec;
    logic        mwait;
    logic [31:0] mcnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .imem_ready(imem_ready),
        .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
        .Rd_E(Rd_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .MemRead_E(MemRead_E), .RegWrite_E(RegWrite_E), .redirect_E(redirect_E),
        .Rd_M(Rd_M), .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M), .RegWrite_M(RegWrite_M),
        .Rd_W(Rd_W), .RegWrite_W(RegWrite_W), .dmem_ack(dmem_ack),
        .pc_wen(pc_wen), .wen_FD(wen_FD), .wen_DE(wen_DE), .wen_EM(wen_EM), .wen_MW(wen_MW),
        .vD(vD), .vE(vE), .vM(vM), .vW(vW), .dmem_req(dmem_req),
        .fwdA_E(fwdA_E), .fwdB_E(fwdB_E), .instret(instret)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ready = 1'b1;
        use_rs1_D = 1'b0; use_rs2_D = 1'b0; Rs1_D = 5'd0; Rs2_D = 5'd0;
        Rd_E = 5'd0; Rs1_E = 5'd0; Rs2_E = 5'd0;
        MemRead_E = 1'b0; RegWrite_E = 1'b0; redirect_E = 1'b0;
        Rd_M = 5'd0; MemRead_M = 1'b0; MemWrite_M = 1'b0; RegWrite_M = 1'b0;
        Rd_W = 5'd0; RegWrite_W = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic fill();
        repeat (4) tick();
    endtask

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (mvec[1] && RegWrite_M && Rd_M != 5'd0 && Rd_M == rs) return 2'b10;
        if (mvec[0] && RegWrite_W && Rd_W != 5'd0 && Rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic test_reset();
        do_reset();
        MemWrite_M = 1'b1; RegWrite_M = 1'b1; Rd_M = 5'd3; Rs1_E = 5'd3;
        #1;
        total++; if ({vD, vE, vM, vW} !== 4'b0000) $display("FAIL reset_valid: got %b want 0000", {vD, vE, vM, vW}); else passed++;
        total++; if (instret !== 32'd0) $display("FAIL reset_instret: got %0d want 0", instret); else passed++;
        total++; if (dmem_req !== 1'b0) $display("FAIL reset_dmem_req: got %b want 0", dmem_req); else passed++;
        total++; if (fwdA_E !== 2'b00) $display("FAIL reset_fwdA: got %b want 00", fwdA_E); else passed++;
        clear_inputs();
    endtask

    task automatic test_straight();
        logic [3:0] exp_v;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            total++; if (pc_wen !== 1'b1) $display("FAIL straight_pc_wen: got %b want 1", pc_wen); else passed++;
            tick();
            exp_v = 4'b1111 << (4 - k);
            total++; if ({vD, vE, vM, vW} !== exp_v) $display("FAIL straight_valid_c%0d: got %b want %b", k, {vD, vE, vM, vW}, exp_v); else passed++;
        end
        repeat (4) tick();
        total++; if (instret !== 32'd5) $display("FAIL straight_instret: got %0d want 5", instret); else passed++;
    endtask

    task automatic test_loaduse();
        do_reset();
        fill();
        MemRead_E = 1'b1; RegWrite_E = 1'b1; Rd_E = 5'd5;
        use_rs1_D = 1'b1; Rs1_D = 5'd5;
        #1;
        total++; if ({pc_wen, wen_FD} !== 2'b00) $display("FAIL loaduse_stall: got %b want 00", {pc_wen, wen_FD}); else passed++;
        total++; if ({wen_DE, wen_EM, wen_MW} !== 3'b111) $display("FAIL loaduse_down_wen: got %b want 111", {wen_DE, wen_EM, wen_MW}); else passed++;
        tick();
        total++; if ({vD, vE, vM, vW} !== 4'b1011) $display("FAIL loaduse_bubble: got %b want 1011", {vD, vE, vM, vW}); else passed++;
        clear_inputs();
        Rd_M = 5'd5; RegWrite_M = 1'b1; MemRead_M = 1'b1; dmem_ack = 1'b1;
        #1;
        total++; if ({dmem_req, pc_wen, wen_MW} !== 3'b111) $display("FAIL loaduse_load_in_m: got %b want 111", {dmem_req, pc_wen, wen_MW}); else passed++;
        tick();
        clear_inputs();
        Rd_W = 5'd5; RegWrite_W = 1'b1; Rs1_E = 5'd5;
        #1;
        total++; if (vM !== 1'b0) $display("FAIL loaduse_bubble_in_m: got %b want 0", vM); else passed++;
        total++; if (fwdA_E !== 2'b01) $display("FAIL loaduse_fwdA: got %b want 01", fwdA_E); else passed++;
        clear_inputs();
    endtask

    task automatic test_redirect();
        do_reset();
        fill();
        redirect_E = 1'b1;
        imem_ready = 1'b0;
        #1;
        total++; if ({pc_wen, wen_FD, wen_DE, wen_EM, wen_MW} !== 5'b11111) $display("FAIL redirect_wen: got %b want 11111", {pc_wen, wen_FD, wen_DE, wen_EM, wen_MW}); else passed++;
        tick();
        redirect_E = 1'b0;
        imem_ready = 1'b1;
        total++; if ({vD, vE, vM, vW} !== 4'b0011) $display("FAIL redirect_squash: got %b want 0011", {vD, vE, vM, vW}); else passed++;
    endtask

    task automatic test_store_wait();
        do_reset();
        fill();
        MemWrite_M = 1'b1;
        dmem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (dmem_req !== 1'b1) $display("FAIL store_req_w%0d: got %b want 1", i, dmem_req); else passed++;
            total++; if ({pc_wen, wen_FD, wen_DE, wen_EM, wen_MW} !== 5'b00000) $display("FAIL store_freeze_w%0d: got %b want 00000", i, {pc_wen, wen_FD, wen_DE, wen_EM, wen_MW}); else passed++;
            tick();
            total++; if ({vD, vE, vM, vW} !== 4'b1111 || instret !== 32'd1) $display("FAIL store_hold_w%0d: got v=%b n=%0d want v=1111 n=1", i, {vD, vE, vM, vW}, instret); else passed++;
        end
        dmem_ack = 1'b1;
        #1;
        total++; if (dmem_req !== 1'b1) $display("FAIL store_req_ack: got %b want 1", dmem_req); else passed++;
        total++; if ({pc_wen, wen_FD, wen_DE, wen_EM, wen_MW} !== 5'b11111) $display("FAIL store_release: got %b want 11111", {pc_wen, wen_FD, wen_DE, wen_EM, wen_MW}); else passed++;
        tick();
        total++; if (instret !== 32'd2) $display("FAIL store_instret: got %0d want 2", instret); else passed++;
        clear_inputs();
    endtask

    task automatic test_fwd();
        do_reset();
        fill();
        Rd_M = 5'd7; RegWrite_M = 1'b1; Rd_W = 5'd7; RegWrite_W = 1'b1;
        Rs2_E = 5'd7; Rs1_E = 5'd3;
        #1;
        total++; if (fwdB_E !== 2'b10) $display("FAIL fwd_m_priority: got %b want 10", fwdB_E); else passed++;
        total++; if (fwdA_E !== 2'b00) $display("FAIL fwd_no_match: got %b want 00", fwdA_E); else passed++;
        Rd_M = 5'd0;
        #1;
        total++; if (fwdB_E !== 2'b01) $display("FAIL fwd_w: got %b want 01", fwdB_E); else passed++;
        Rd_W = 5'd0; Rs2_E = 5'd0;
        #1;
        total++; if (fwdB_E !== 2'b00) $display("FAIL fwd_x0: got %b want 00", fwdB_E); else passed++;
        clear_inputs();
    endtask

    task automatic test_rst_in_wait();
        do_reset();
        fill();
        MemRead_M = 1'b1;
        dmem_ack = 1'b0;
        tick();
        tick();
        total++; if (dmem_req !== 1'b1) $display("FAIL rstwait_req_before: got %b want 1", dmem_req); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (dmem_req !== 1'b0) $display("FAIL rstwait_req: got %b want 0", dmem_req); else passed++;
        total++; if ({vD, vE, vM, vW} !== 4'b0000 || instret !== 32'd0) $display("FAIL rstwait_state: got v=%b n=%0d want v=0000 n=0", {vD, vE, vM, vW}, instret); else passed++;
        clear_inputs();
    endtask

    task automatic test_random();
        logic       e_req, e_frz, e_redir, e_lu;
        logic [4:0] e_wen;
        logic [3:0] n_vec;
        logic       n_wait;
        logic [31:0] n_cnt;
        logic [1:0] e_fa, e_fb;
        do_reset();
        mvec = 4'b0000; mwait = 1'b0; mcnt = 32'd0;
        for (int c = 0; c < 300; c++) begin
            rst        = ($urandom_range(0, 59) == 0);
            imem_ready = ($urandom_range(0, 4) != 0);
            use_rs1_D  = $urandom_range(0, 1) == 1;
            use_rs2_D  = $urandom_range(0, 1) == 1;
            Rs1_D = 5'($urandom_range(0, 3)); Rs2_D = 5'($urandom_range(0, 3));
            Rd_E  = 5'($urandom_range(0, 3)); Rs1_E = 5'($urandom_range(0, 3)); Rs2_E = 5'($urandom_range(0, 3));
            MemRead_E  = ($urandom_range(0, 2) == 0);
            RegWrite_E = $urandom_range(0, 1) == 1;
            redirect_E = ($urandom_range(0, 6) == 0);
            Rd_M = 5'($urandom_range(0, 3)); Rd_W = 5'($urandom_range(0, 3));
            MemRead_M  = ($urandom_range(0, 3) == 0);
            MemWrite_M = ($urandom_range(0, 3) == 0);
            RegWrite_M = $urandom_range(0, 1) == 1;
            RegWrite_W = $urandom_range(0, 1) == 1;
            dmem_ack   = $urandom_range(0, 1) == 1;
            #1;
            e_req   = mwait | (mvec[1] & (MemRead_M | MemWrite_M));
            e_frz   = e_req & ~dmem_ack;
            e_redir = redirect_E & mvec[2];
            e_lu    = mvec[3] & mvec[2] & MemRead_E & (Rd_E != 0) &
                      ((use_rs1_D & (Rs1_D == Rd_E)) | (use_rs2_D & (Rs2_D == Rd_E)));
            if (e_frz) begin
                e_wen = 5'b00000; n_vec = mvec;
            end else if (e_redir) begin
                e_wen = 5'b11111; n_vec = {2'b00, mvec[2:1]};
            end else if (e_lu) begin
                e_wen = 5'b00111; n_vec = {mvec[3], 1'b0, mvec[2:1]};
            end else if (!imem_ready) begin
                e_wen = 5'b01111; n_vec = {1'b0, mvec[3:1]};
            end else begin
                e_wen = 5'b11111; n_vec = {1'b1, mvec[3:1]};
            end
            n_wait = e_frz;
            n_cnt  = mcnt + ((!e_frz && mvec[1]) ? 32'd1 : 32'd0);
            e_fa = model_fwd(Rs1_E);
            e_fb = model_fwd(Rs2_E);
            total++; if (dmem_req !== e_req) $display("FAIL rand_req c%0d: got %b want %b", c, dmem_req, e_req); else passed++;
            total++; if ({pc_wen, wen_FD, wen_DE, wen_EM, wen_MW} !== e_wen) $display("FAIL rand_wen c%0d: got %b want %b", c, {pc_wen, wen_FD, wen_DE, wen_EM, wen_MW}, e_wen); else passed++;
            total++; if ({fwdA_E, fwdB_E} !== {e_fa, e_fb}) $display("FAIL rand_fwd c%0d: got %b want %b", c, {fwdA_E, fwdB_E}, {e_fa, e_fb}); else passed++;
            tick();
            if (rst) begin
                mvec = 4'b0000; mwait = 1'b0; mcnt = 32'd0;
            end else begin
                mvec = n_vec; mwait = n_wait; mcnt = n_cnt;
            end
            total++; if ({vD, vE, vM, vW} !== mvec) $display("FAIL rand_valid c%0d: got %b want %b", c, {vD, vE, vM, vW}, mvec); else passed++;
            total++; if (instret !== mcnt) $display("FAIL rand_instret c%0d: got %0d want %0d", c, instret, mcnt); else passed++;
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_straight();
        test_loaduse();
        test_redirect();
        test_store_wait();
        test_fwd();
        test_rst_in_wait();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control for the five-stage RV32 core: the unit that drives the `valid` (write-enable) inputs of the F/D, D/E, E/M and M/W data buffers, and tracks which slot in each stage holds a real instruction. It detects load-use hazards, branch/jump redirects, instruction-fetch wait and data-memory handshake wait. From these it decides, each cycle, which buffers advance, hold or receive a bubble. It also produces forwarding selects for the E stage and counts retired instructions.

## Interface
- `CNT_W`, default 32: width of the retire counter.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_ready` in 1: fetch data valid this cycle.
- `use_rs1_D`, `use_rs2_D` in 1: the instruction in D reads rs1 / rs2.
- `Rs1_D`, `Rs2_D` in 5: source register indices in D.
- `Rd_E`, `Rs1_E`, `Rs2_E` in 5; `MemRead_E`, `RegWrite_E` in 1: E-stage fields.
- `redirect_E` in 1: a taken branch or jump resolved in E.
- `Rd_M` in 5; `MemRead_M`, `MemWrite_M`, `RegWrite_M` in 1: M-stage fields.
- `Rd_W` in 5; `RegWrite_W` in 1: W-stage fields.
- `dmem_ack` in 1: data memory completes the request.
- `pc_wen` out 1: PC register write enable.
- `wen_FD`, `wen_DE`, `wen_EM`, `wen_MW` out 1: connect to the `valid` port of each data buffer.
- `vD`, `vE`, `vM`, `vW` out 1: slot-valid bits for each stage.
- `dmem_req` out 1: data memory request.
- `fwdA_E`, `fwdB_E` out 2: forwarding selects. 00 = register file, 10 = from M, 01 = from W.
- `instret` out CNT_W: count of retired instructions.

## Operation
- Hazard conditions:
  - `freeze` = M-stage memory wait (see FSM) and not yet acked. All `wen_*` = 0, `pc_wen` = 0, and all valid bits hold.
  - `redirect` = `redirect_E & vE`. Then `pc_wen` = 1 and all `wen_*` = 1. Next state: `vD` ← 0, `vE` ← 0, `vM` ← 1, `vW` ← `vM`.
  - `loaduse` = `vD & vE & MemRead_E & Rd_E != 0 & ((use_rs1_D & Rs1_D == Rd_E) | (use_rs2_D & Rs2_D == Rd_E))`. Then `pc_wen` = `wen_FD` = 0 and `wen_DE`/`wen_EM`/`wen_MW` = 1. Next state: `vE` ← 0 (bubble), `vD` holds, and the downstream valid bits shift.
  - `fetchwait` = `!imem_ready`. Then `pc_wen` = 0 and `wen_FD` = 1 (loads garbage). Next state: `vD` ← 0, and the rest of the pipeline advances.
  - Normal: everything advances. `vD` ← 1, `vE` ← `vD`, `vM` ← `vE`, `vW` ← `vM`.
- Priority: `freeze` > `redirect` > `loaduse` > `fetchwait` > normal. Loaduse plus fetchwait in the same cycle resolves as loaduse; the F/D buffer holds.
- Bubbles are expressed only through the valid bits. The data buffers may load stale data, and downstream logic gates side effects with `v*`.
- Memory FSM, states `M_IDLE`, `M_WAIT`:
  - `M_IDLE`: `dmem_req` = `vM & (MemRead_M | MemWrite_M)`.
    - req & ack: no freeze, stay in `M_IDLE`.
    - req & !ack: freeze, go to `M_WAIT`.
  - `M_WAIT`: `dmem_req` = 1 and freeze.
    - ack: release the freeze this cycle (the pipeline advances), go to `M_IDLE`.
- Forwarding:
  - `fwdA_E` = 10 if `vM & RegWrite_M & Rd_M != 0 & Rd_M == Rs1_E`.
  - Else 01 if the same condition holds for W.
  - Else 00.
  - M has priority over W. `fwdB_E` is identical, using `Rs2_E`.
- `instret` increments on an edge where `wen_MW & vM`, i.e. a valid instruction enters W. It wraps from all-ones to 0.

## Timing
- All `wen_*`, `pc_wen`, `dmem_req` and `fwd*` outputs are combinational from current state and inputs, valid in the same cycle.
- Valid bits, FSM state and `instret` are registered, updated on the edge.
- Reset values:
  - `vD` = `vE` = `vM` = `vW` = 0.
  - FSM = `M_IDLE`.
  - `instret` = 0.
  - Hence right after reset `dmem_req` = 0 and `fwd*` = 00.
- First valid instruction: appears in `vD` one cycle after the first fetch with `imem_ready` = 1, and reaches `vW` 3 cycles later absent stalls.
- Load-use costs exactly 1 bubble. A redirect squashes exactly 2 slots.
- Reset asserted during `M_WAIT`: returns to `M_IDLE` with `dmem_req` = 0 on the next cycle.
- A redirect raised while frozen is not acted on until the freeze releases; `vE` and `redirect_E` are held.

## Structure
- Shared package `pipe_pkg`:
  - FSM state enum `M_IDLE`/`M_WAIT`.
  - Forward-select constants `FWD_RF` = 00, `FWD_W` = 01, `FWD_M` = 10.
- One sub-module is natural, `fwd_unit`: the combinational forward-select logic, instantiated once per operand.
- Valid bits and `instret` use the existing `Reg` primitive (reset value 0, wen).

## Test plan
- Straight-line code, `imem_ready` = 1, no memory ops -> `vD..vW` become 1 on cycles 1..4 after reset; `instret` = 5 after 8 cycles.
- `lw x5` in E, and D uses `rs1` = `x5` -> one cycle with `pc_wen` = `wen_FD` = 0 and next `vE` = 0. The following cycle has `fwdA_E` = 01 when the load is in W.
- `redirect_E` = 1 with `vE` = 1 -> `pc_wen` = 1; next cycle `vD` = `vE` = 0, `vM` = 1.
- Store in M with `dmem_ack` low for 3 cycles -> `dmem_req` = 1 for 4 cycles, all `wen_*` = 0 for 3 cycles; the pipeline advances on the ack cycle.
- `Rd_M` = `Rd_W` = 7 (both writing), `Rs2_E` = 7 -> `fwdB_E` = 10. With `Rd_M` = 0 -> `fwdB_E` = 01.
- `rst` pulsed during `M_WAIT` -> next cycle `dmem_req` = 0, all `v*` = 0, `instret` = 0.
